// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle logic/shift ops, radix-4 Booth MUL,
// non-restoring signed DIV, all under a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c_hi,
  output logic [WIDTH-1:0] c_lo,
  output logic             div_by_zero
);

  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam int HW   = WIDTH + 2;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [WIDTH-1:0] WL       = WIDTH'(WIDTH);
  localparam logic [CNTW-1:0]  MUL_LAST = CNTW'(WIDTH/2 - 1);
  localparam logic [CNTW-1:0]  DIV_LAST = CNTW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [HW-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] chi_q, chi_d;
  logic [WIDTH-1:0] clo_q, clo_d;
  logic             dz_q, dz_d;

  // single-cycle datapath
  logic [WIDTH-1:0]   alu_lo;
  logic [WIDTH-1:0]   rot_amt;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic               shr_big;

  assign rot_amt = b_q % WL;
  assign rot_r   = {a_q, a_q} >> rot_amt;
  assign rot_l   = {a_q, a_q} << rot_amt;
  assign shr_big = (b_q >= WL);

  always_comb begin
    alu_lo = '0;
    case (op_q)
      OP_ADD:  alu_lo = a_q + b_q;
      OP_SUB:  alu_lo = a_q - b_q;
      OP_SHR:  alu_lo = shr_big ? '0 : (a_q >> b_q);
      OP_SHRA: alu_lo = shr_big ? {WIDTH{a_q[WIDTH-1]}}
                                : WIDTH'($signed(a_q) >>> b_q);
      OP_SHL:  alu_lo = shr_big ? '0 : (a_q << b_q);
      OP_ROR:  alu_lo = rot_r[WIDTH-1:0];
      OP_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_AND:  alu_lo = a_q & b_q;
      OP_OR:   alu_lo = a_q | b_q;
      OP_NEG:  alu_lo = '0 - b_q;
      OP_NOT:  alu_lo = ~b_q;
      default: alu_lo = '0;
    endcase
  end

  // Booth step: hi_q is the accumulator, lo_q the multiplier
  logic [HW-1:0]         mc, mc2, addend, bsum;
  logic [HW+WIDTH:0]     bwide, bshift;

  assign mc  = {{2{a_q[WIDTH-1]}}, a_q};
  assign mc2 = mc << 1;

  always_comb begin
    addend = '0;
    case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: addend = mc;
      3'b011:         addend = mc2;
      3'b100:         addend = '0 - mc2;
      3'b101, 3'b110: addend = '0 - mc;
      default:        addend = '0;
    endcase
  end

  assign bsum   = hi_q + addend;
  assign bwide  = {bsum, lo_q, qm1_q};
  assign bshift = {{2{bsum[HW-1]}}, bwide[HW+WIDTH:2]};

  // Non-restoring step on magnitudes; signs fixed up in FIX
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [HW-1:0]    dvs, rsh, rnew, rfix;
  logic [WIDTH-1:0] qnew, rw;

  assign a_neg = a_q[WIDTH-1];
  assign b_neg = b_q[WIDTH-1];
  assign a_mag = a_neg ? ('0 - a_q) : a_q;
  assign b_mag = b_neg ? ('0 - b_q) : b_q;
  assign dvs   = {2'b00, b_mag};
  assign rsh   = {hi_q[HW-2:0], lo_q[WIDTH-1]};
  assign rnew  = hi_q[HW-1] ? (rsh + dvs) : (rsh - dvs);
  assign qnew  = {lo_q[WIDTH-2:0], ~rnew[HW-1]};
  assign rfix  = hi_q[HW-1] ? (hi_q + dvs) : hi_q;
  assign rw    = rfix[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    chi_d   = chi_q;
    clo_d   = clo_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          cnt_d  = '0;
          if (op_q == OP_MUL) begin
            hi_d    = '0;
            lo_d    = b_q;
            qm1_d   = 1'b0;
            state_d = S_MUL;
          end else if (op_q == OP_DIV && b_q == '0) begin
            chi_d   = a_q;
            clo_d   = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else if (op_q == OP_DIV) begin
            hi_d    = '0;
            lo_d    = a_mag;
            state_d = S_DIV;
          end else begin
            chi_d   = '0;
            clo_d   = alu_lo;
            state_d = S_DONE;
          end
        end else if (start) begin
          pend_d = 1'b1;
          op_d   = op;
          a_d    = a;
          b_d    = b;
          dz_d   = 1'b0;
        end
      end
      S_MUL: begin
        hi_d  = bshift[HW+WIDTH:WIDTH+1];
        lo_d  = bshift[WIDTH:1];
        qm1_d = bshift[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) begin
          chi_d   = bshift[2*WIDTH:WIDTH+1];
          clo_d   = bshift[WIDTH:1];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        hi_d  = rnew;
        lo_d  = qnew;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        clo_d   = (a_neg ^ b_neg) ? ('0 - lo_q) : lo_q;
        chi_d   = a_neg ? ('0 - rw) : rw;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      chi_q   <= '0;
      clo_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      chi_q   <= chi_d;
      clo_q   <= clo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy        = pend_q | (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign c_hi        = chi_q;
  assign c_lo        = clo_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: 32-bit instance plus an 8-bit instance
// for the narrow MUL/DIV corners.
module tb_seq_alu;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] c_hi, c_lo;

  logic        start8 = 1'b0;
  logic [4:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) u_dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .c_hi(c_hi), .c_lo(c_lo), .div_by_zero(div_by_zero)
  );

  seq_alu #(.WIDTH(8)) u_d8 (
    .clk(clk), .clr_n(clr_n), .start(start8), .op(op8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .c_hi(hi8), .c_lo(lo8), .div_by_zero(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for done (bounded), check latency, done count
  // and results.
  task automatic do_op(input string tag, input logic [4:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input int elat, input logic [31:0] ehi,
                       input logic [31:0] elo);
    int lat, nd;
    lat = -1;
    nd  = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (lat < 0) lat = i;
      end
      if (lat >= 0 && i >= lat + 1) break;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_hi"}, {32'h0, c_hi}, {32'h0, ehi});
    chk({tag, "_lo"}, {32'h0, c_lo}, {32'h0, elo});
    chk({tag, "_ndone"}, 64'(nd), 64'd1);
  endtask

  task automatic do_op8(input string tag, input logic [4:0] o,
                        input logic [7:0] x, input logic [7:0] y,
                        input int elat, input logic [7:0] ehi,
                        input logic [7:0] elo);
    int lat;
    lat = -1;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done8 && lat < 0) lat = i;
      if (lat >= 0 && i >= lat + 1) break;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_hi"}, {56'h0, hi8}, {56'h0, ehi});
    chk({tag, "_lo"}, {56'h0, lo8}, {56'h0, elo});
  endtask

  initial begin
    int lat, nd;
    logic b1, b17, b18;

    #12;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hi", {32'h0, c_hi}, 64'h0);
    chk("rst_lo", {32'h0, c_lo}, 64'h0);
    chk("rst_dz", {63'h0, div_by_zero}, 64'h0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (2) @(posedge clk);

    // MUL with busy profile
    @(negedge clk);
    op = OP_MUL; a = 32'hFFFFFFF9; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; b1 = 1'b0; b17 = 1'b0; b18 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) b1 = busy;
      if (i == 17) b17 = busy;
      if (i == 18) b18 = busy;
      if (done && lat < 0) lat = i;
    end
    chk("mul7_lat", 64'(lat), 64'd17);
    chk("mul7_hi", {32'h0, c_hi}, 64'hFFFFFFFF);
    chk("mul7_lo", {32'h0, c_lo}, 64'hFFFFFFD6);
    chk("mul7_busy1", {63'h0, b1}, 64'h1);
    chk("mul7_busy17", {63'h0, b17}, 64'h1);
    chk("mul7_busy18", {63'h0, b18}, 64'h0);

    do_op("mulmin", OP_MUL, 32'h80000000, 32'h80000000, 17,
          32'h40000000, 32'h0);
    do_op("mulmax", OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 17,
          32'h3FFFFFFF, 32'h00000001);
    do_op("mulm1", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 17,
          32'h0, 32'h1);

    do_op("div17", OP_DIV, 32'hFFFFFFEF, 32'd5, 34,
          32'hFFFFFFFE, 32'hFFFFFFFD);
    chk("div17_dz", {63'h0, div_by_zero}, 64'h0);
    do_op("div0", OP_DIV, 32'd9, 32'd0, 1, 32'd9, 32'hFFFFFFFF);
    chk("div0_dz", {63'h0, div_by_zero}, 64'h1);
    do_op("div100", OP_DIV, 32'd100, 32'd7, 34, 32'd2, 32'd14);
    chk("div100_dz", {63'h0, div_by_zero}, 64'h0);
    do_op("div7n2", OP_DIV, 32'd7, 32'hFFFFFFFE, 34,
          32'd1, 32'hFFFFFFFD);
    do_op("divmin", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34,
          32'h0, 32'h80000000);

    do_op("shra40", OP_SHRA, 32'h80000000, 32'd40, 1,
          32'h0, 32'hFFFFFFFF);
    do_op("shr40", OP_SHR, 32'h80000000, 32'd40, 1, 32'h0, 32'h0);
    do_op("rol33", OP_ROL, 32'h80000001, 32'd33, 1,
          32'h0, 32'h00000003);
    do_op("shr4", OP_SHR, 32'h80000000, 32'd4, 1,
          32'h0, 32'h08000000);
    do_op("shra4", OP_SHRA, 32'h80000000, 32'd4, 1,
          32'h0, 32'hF8000000);
    do_op("shl31", OP_SHL, 32'd1, 32'd31, 1, 32'h0, 32'h80000000);
    do_op("shl32", OP_SHL, 32'd1, 32'd32, 1, 32'h0, 32'h0);
    do_op("ror4", OP_ROR, 32'd1, 32'd4, 1, 32'h0, 32'h10000000);
    do_op("add", OP_ADD, 32'h12345678, 32'h11111111, 1,
          32'h0, 32'h23456789);
    do_op("sub", OP_SUB, 32'd5, 32'd7, 1, 32'h0, 32'hFFFFFFFE);
    do_op("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1,
          32'h0, 32'hF000F000);
    do_op("or", OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, 1,
          32'h0, 32'hFFF0FFF0);
    do_op("neg", OP_NEG, 32'h0, 32'd1, 1, 32'h0, 32'hFFFFFFFF);
    do_op("not", OP_NOT, 32'h0, 32'h0F0F0000, 1, 32'h0, 32'hF0F0FFFF);
    do_op("bad", 5'b11111, 32'h1234, 32'h5678, 1, 32'h0, 32'h0);

    // start held high while busy must be ignored
    @(negedge clk);
    op = OP_MUL; a = 32'hFFFFFFF9; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    op = OP_DIV; a = 32'd100; b = 32'd7;
    lat = -1; nd = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 5) start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) lat = i;
      end
    end
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_lat", 64'(lat), 64'd17);
    chk("ign_hi", {32'h0, c_hi}, 64'hFFFFFFFF);
    chk("ign_lo", {32'h0, c_lo}, 64'hFFFFFFD6);

    // asynchronous reset in the middle of a DIV
    @(negedge clk);
    op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk("arst_hi", {32'h0, c_hi}, 64'h0);
    chk("arst_lo", {32'h0, c_lo}, 64'h0);
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_done", {63'h0, done}, 64'h0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("arst_nodone", 64'(nd), 64'd0);
    do_op("addwrap", OP_ADD, 32'hFFFFFFFF, 32'd1, 1, 32'h0, 32'h0);

    do_op8("mul8", OP_MUL, 8'h80, 8'h80, 5, 8'h40, 8'h00);
    do_op8("div8", OP_DIV, 8'h80, 8'h03, 10, 8'hFE, 8'hD6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
